// File: rtl/exe_if.sv
// ID/EX inputs and EX-stage results for the execute stage.
// master drives the ID/EX side; slave is the execute stage.
interface exe_if;
    logic [3:0]  EXE_CMD;
    logic        Mem_R_EN;
    logic        Mem_W_EN;
    logic        S;
    logic        B;
    logic        imm;
    logic [31:0] pc;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] fwd_mem;
    logic [31:0] fwd_wb;
    logic [31:0] ALU_result;
    logic [31:0] store_data;
    logic [31:0] branch_addr;
    logic        branch_taken;
    logic [3:0]  status;

    modport master (
        output EXE_CMD, Mem_R_EN, Mem_W_EN, S, B, imm,
        output pc, Val_Rn, Val_Rm, shift_operand, signed_imm_24,
        output sel_src1, sel_src2, fwd_mem, fwd_wb,
        input  ALU_result, store_data, branch_addr,
        input  branch_taken, status
    );

    modport slave (
        input  EXE_CMD, Mem_R_EN, Mem_W_EN, S, B, imm,
        input  pc, Val_Rn, Val_Rm, shift_operand, signed_imm_24,
        input  sel_src1, sel_src2, fwd_mem, fwd_wb,
        output ALU_result, store_data, branch_addr,
        output branch_taken, status
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 generation, ALU,
// registered {N,Z,C,V} status and branch target adder.
module exe_stage (
    input  logic clk,
    input  logic rst,
    exe_if.slave bus
);
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    function automatic logic [31:0] ror32(
        input logic [31:0] x,
        input logic [4:0]  n
    );
        // shifting by 32 yields 0, so n=0 returns x unchanged
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    logic [31:0] op1;
    logic [31:0] rm;
    logic [31:0] val2;
    logic [31:0] shifted;
    logic [31:0] res;
    logic [32:0] sum;
    logic [3:0]  alu_op;
    logic [3:0]  flags;
    logic [3:0]  status_d;
    logic [3:0]  status_q;
    logic        mem_en;
    logic        c_in;
    logic        c_out;
    logic        v_out;
    logic        upd;
    logic [4:0]  sh_amt;

    assign mem_en = bus.Mem_R_EN | bus.Mem_W_EN;
    assign c_in   = status_q[1];
    assign sh_amt = bus.shift_operand[11:7];

    always_comb begin
        op1 = bus.Val_Rn;
        unique case (bus.sel_src1)
            2'b01:   op1 = bus.fwd_mem;
            2'b10:   op1 = bus.fwd_wb;
            default: op1 = bus.Val_Rn;
        endcase
    end

    always_comb begin
        rm = bus.Val_Rm;
        unique case (bus.sel_src2)
            2'b01:   rm = bus.fwd_mem;
            2'b10:   rm = bus.fwd_wb;
            default: rm = bus.Val_Rm;
        endcase
    end

    always_comb begin
        shifted = rm;
        unique case (bus.shift_operand[6:5])
            2'b00:   shifted = rm << sh_amt;
            2'b01:   shifted = rm >> sh_amt;
            2'b10:   shifted = 32'($signed(rm) >>> sh_amt);
            default: shifted = ror32(rm, sh_amt);
        endcase
    end

    always_comb begin
        val2 = shifted;
        if (bus.imm)
            val2 = ror32({24'd0, bus.shift_operand[7:0]},
                         {bus.shift_operand[11:8], 1'b0});
        else if (mem_en)
            val2 = {20'd0, bus.shift_operand};
    end

    // address generation for loads/stores always adds
    assign alu_op = mem_en ? OP_ADD : bus.EXE_CMD;

    always_comb begin
        sum   = '0;
        res   = '0;
        c_out = status_q[1];
        v_out = status_q[0];
        upd   = 1'b1;
        unique case (alu_op)
            OP_MOV: res = val2;
            OP_MVN: res = ~val2;
            OP_AND: res = op1 & val2;
            OP_ORR: res = op1 | val2;
            OP_EOR: res = op1 ^ val2;
            OP_ADD, OP_ADC: begin
                sum = {1'b0, op1} + {1'b0, val2}
                    + {32'd0, (alu_op == OP_ADC) & c_in};
                res   = sum[31:0];
                c_out = sum[32];
                v_out = (op1[31] == val2[31]) &&
                        (res[31] != op1[31]);
            end
            OP_SUB, OP_SBC: begin
                // carry out of op1 + ~val2 + cin is NOT borrow
                sum = {1'b0, op1} + {1'b0, ~val2}
                    + {32'd0, (alu_op == OP_SUB) | c_in};
                res   = sum[31:0];
                c_out = sum[32];
                v_out = (op1[31] != val2[31]) &&
                        (res[31] != op1[31]);
            end
            default: begin
                res = '0;
                upd = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags = status_q;
        if (upd)
            flags = {res[31], res == 32'd0, c_out, v_out};
    end

    always_comb begin
        status_d = status_q;
        if (bus.S)
            status_d = flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            status_q <= 4'b0000;
        else
            status_q <= status_d;
    end

    assign bus.ALU_result   = res;
    assign bus.store_data   = rm;
    assign bus.branch_taken = bus.B;
    assign bus.status       = status_q;
    assign bus.branch_addr  = bus.pc +
        {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_exe_stage;
    logic clk;
    logic rst;

    exe_if u_if ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] ba;
        logic        bt;
        logic [3:0]  stat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        u_if.EXE_CMD       = 4'd0;
        u_if.Mem_R_EN      = 1'b0;
        u_if.Mem_W_EN      = 1'b0;
        u_if.S             = 1'b0;
        u_if.B             = 1'b0;
        u_if.imm           = 1'b0;
        u_if.pc            = 32'd0;
        u_if.Val_Rn        = 32'd0;
        u_if.Val_Rm        = 32'd0;
        u_if.shift_operand = 12'd0;
        u_if.signed_imm_24 = 24'd0;
        u_if.sel_src1      = 2'd0;
        u_if.sel_src2      = 2'd0;
        u_if.fwd_mem       = 32'd0;
        u_if.fwd_wb        = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_v(string nm, logic [31:0] alu,
                            logic [31:0] st, logic [31:0] ba,
                            logic bt, logic [3:0] stat);
        exp_t e;
        e.name = nm;
        e.alu  = alu;
        e.st   = st;
        e.ba   = ba;
        e.bt   = bt;
        e.stat = stat;
        sb.push_back(e);
    endtask

    task automatic cmp(string nm, string fld,
                       logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "alu", u_if.ALU_result, e.alu);
            cmp(e.name, "store", u_if.store_data, e.st);
            cmp(e.name, "baddr", u_if.branch_addr, e.ba);
            cmp(e.name, "btaken", {31'd0, u_if.branch_taken},
                {31'd0, e.bt});
            cmp(e.name, "status", {28'd0, u_if.status},
                {28'd0, e.stat});
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1;
        idle();

        step();
        expect_v("reset", 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000);

        step(); rst = 1'b0;
        u_if.EXE_CMD = 4'b0010; u_if.S = 1'b1; u_if.imm = 1'b1;
        u_if.shift_operand = 12'h001; u_if.Val_Rn = 32'h7FFFFFFF;
        expect_v("add_ovf", 32'h80000000, 0, 0, 0, 4'b0000);

        step();
        u_if.EXE_CMD = 4'b0001; u_if.imm = 1'b1;
        u_if.shift_operand = 12'h4FF;
        expect_v("mov_rot", 32'hFF000000, 0, 0, 0, 4'b1001);

        step();
        u_if.EXE_CMD = 4'b0001; u_if.shift_operand = 12'h0C3;
        u_if.Val_Rm = 32'h80000001;
        expect_v("mov_asr", 32'hC0000000, 32'h80000001, 0, 0,
                 4'b1001);

        step();
        u_if.EXE_CMD = 4'b0100; u_if.S = 1'b1;
        u_if.Val_Rn = 32'd5; u_if.Val_Rm = 32'd5;
        expect_v("sub_zero", 32'h0, 32'd5, 0, 0, 4'b1001);

        step();
        u_if.EXE_CMD = 4'b0101; u_if.S = 1'b1;
        u_if.Val_Rn = 32'd5; u_if.Val_Rm = 32'd5;
        expect_v("sbc_c1", 32'h0, 32'd5, 0, 0, 4'b0110);

        step();
        u_if.EXE_CMD = 4'b0100; u_if.Mem_R_EN = 1'b1;
        u_if.Val_Rn = 32'h100; u_if.shift_operand = 12'h004;
        u_if.Val_Rm = 32'hDEADBEEF;
        expect_v("ldr", 32'h104, 32'hDEADBEEF, 0, 0, 4'b0110);

        step();
        u_if.B = 1'b1; u_if.pc = 32'h20;
        u_if.signed_imm_24 = 24'hFFFFFE;
        u_if.sel_src1 = 2'b01; u_if.fwd_mem = 32'h10;
        u_if.EXE_CMD = 4'b0010; u_if.imm = 1'b1;
        u_if.shift_operand = 12'h001;
        expect_v("branch_fwd", 32'h11, 0, 32'h18, 1, 4'b0110);

        step();
        u_if.EXE_CMD = 4'b0011; u_if.S = 1'b1; u_if.imm = 1'b1;
        u_if.shift_operand = 12'h001; u_if.Val_Rn = 32'hFFFFFFFF;
        expect_v("adc_cin", 32'h1, 0, 0, 0, 4'b0110);

        step();
        u_if.EXE_CMD = 4'b0110; u_if.S = 1'b1;
        u_if.sel_src2 = 2'b10; u_if.fwd_wb = 32'h12345678;
        u_if.Val_Rn = 32'h0F0F0F0F;
        expect_v("and_fwdwb", 32'h02040608, 32'h12345678, 0, 0,
                 4'b0010);

        step();
        u_if.EXE_CMD = 4'b1000; u_if.sel_src1 = 2'b11;
        u_if.fwd_mem = 32'hAAAAAAAA; u_if.Val_Rn = 32'hFFFF0000;
        u_if.shift_operand = 12'h220; u_if.Val_Rm = 32'hF0000000;
        expect_v("eor_lsr", 32'hF0FF0000, 32'hF0000000, 0, 0,
                 4'b0010);

        step();
        u_if.EXE_CMD = 4'b1001; u_if.shift_operand = 12'h460;
        u_if.Val_Rm = 32'h000000AB;
        expect_v("mvn_ror", 32'h54FFFFFF, 32'hAB, 0, 0, 4'b0010);

        step();
        u_if.EXE_CMD = 4'b0111; u_if.Mem_W_EN = 1'b1;
        u_if.Val_Rn = 32'd1; u_if.shift_operand = 12'hFFF;
        u_if.Val_Rm = 32'h55;
        expect_v("str", 32'h1000, 32'h55, 0, 0, 4'b0010);

        step();
        u_if.EXE_CMD = 4'b0000; u_if.S = 1'b1;
        u_if.Val_Rn = 32'h1234;
        expect_v("bad_op", 32'h0, 0, 0, 0, 4'b0010);

        step();
        u_if.EXE_CMD = 4'b0100; u_if.S = 1'b1; u_if.imm = 1'b1;
        u_if.shift_operand = 12'h001; u_if.Val_Rn = 32'h80000000;
        expect_v("sub_ovf", 32'h7FFFFFFF, 0, 0, 0, 4'b0010);

        step();
        u_if.EXE_CMD = 4'b1001; u_if.S = 1'b1; u_if.imm = 1'b1;
        expect_v("mvn_flags", 32'hFFFFFFFF, 0, 0, 0, 4'b0011);

        step();
        expect_v("hold", 32'h0, 0, 0, 0, 4'b1011);

        step();
        u_if.EXE_CMD = 4'b1001; u_if.S = 1'b1; u_if.imm = 1'b1;
        rst = 1'b1;
        expect_v("rst_mid", 32'hFFFFFFFF, 0, 0, 0, 4'b0000);

        step(); rst = 1'b0;
        u_if.EXE_CMD = 4'b0001; u_if.imm = 1'b1;
        expect_v("post_rst", 32'h0, 0, 0, 0, 4'b0000);

        step();
        u_if.EXE_CMD = 4'b0100; u_if.S = 1'b1; u_if.imm = 1'b1;
        u_if.shift_operand = 12'h001;
        expect_v("sub_borrow", 32'hFFFFFFFF, 0, 0, 0, 4'b0000);

        step();
        expect_v("final", 32'h0, 0, 0, 0, 4'b1000);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, clock; all state changes on the rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, asynchronous, active-high reset.
REQ-003 The block SHALL have these ports: EXE_CMD, input, 4, ALU opcode from the ID/EX register.
REQ-004 The block SHALL have these ports: Mem_R_EN, Mem_W_EN, S, B, imm, input, 1 each, ID/EX control bits.
REQ-005 The block SHALL have these ports: pc, Val_Rn, Val_Rm, input, 32 each, ID/EX datapath values.
REQ-006 The block SHALL have these ports: shift_operand, input, 12; signed_imm_24, input, 24.
REQ-007 The block SHALL have these ports: sel_src1, sel_src2, input, 2 each, forwarding selects (00 ID/EX value, 01 fwd_mem, 10 fwd_wb, 11 treated as 00).
REQ-008 The block SHALL have these ports: fwd_mem, fwd_wb, input, 32 each, forwarded results from the MEM and WB stages.
REQ-009 The block SHALL have these ports: ALU_result, output, 32; store_data, output, 32, forwarded Rm; branch_addr, output, 32; branch_taken, output, 1 (equal to B); status, output, 4, registered {N,Z,C,V}.

Function
REQ-010 The block SHALL form op1 from Val_Rn or a forward per sel_src1, and rm from Val_Rm or a forward per sel_src2; store_data SHALL equal rm.
REQ-011 When imm=1, Val2 SHALL be zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8].
REQ-012 When imm=0 and (Mem_R_EN|Mem_W_EN)=1, Val2 SHALL be zero-extended shift_operand[11:0].
REQ-013 Otherwise, Val2 SHALL be rm shifted by shift_operand[11:7] according to shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; an amount of 0 SHALL pass rm unchanged.
REQ-014 ALU opcodes SHALL be:
- 0001 MOV=Val2
- 1001 MVN=~Val2
- 0010 ADD=op1+Val2
- 0011 ADC=op1+Val2+C
- 0100 SUB=op1-Val2
- 0101 SBC=op1-Val2-!C
- 0110 AND
- 0111 ORR
- 1000 EOR
- any other code SHALL produce 0 with no flag effect.
REQ-015 When Mem_R_EN|Mem_W_EN=1, the ALU SHALL compute ADD regardless of EXE_CMD.
REQ-016 The ALU SHALL be combinational; ALU_result SHALL be valid in the same cycle as its inputs, i.e. zero added latency.
REQ-017 Flags SHALL be: N=result[31]; Z=(result==0).
REQ-018 For ADD/ADC, C SHALL be carry-out of the 33-bit sum.
REQ-019 For SUB/SBC, C SHALL be NOT borrow.
REQ-020 V SHALL be two's-complement signed overflow for the arithmetic ops.
REQ-021 For MOV, MVN, AND, ORR and EOR, C and V SHALL be passed from the current status unchanged.
REQ-022 The status register SHALL load the ALU flags on the rising clk edge when S=1 and hold otherwise; ADC/SBC SHALL read the pre-update C.
REQ-023 branch_addr SHALL be pc + (sign-extended signed_imm_24 << 2), wrapping modulo 2^32.
REQ-024 When B=1 and S=1 in the same cycle, the status update SHALL still occur as specified.

Reset
REQ-025 rst=1 SHALL clear status to 4'b0000 immediately and asynchronously, including a reset asserted mid-cycle while S=1.
REQ-026 The combinational outputs SHALL follow their inputs during reset.
REQ-027 The first clk edge after rst deasserts SHALL behave per REQ-022.

Verification
REQ-028 ADD with S=1, op1=0x7FFFFFFF, Val2=1 via imm (shift_operand=0x001) -> ALU_result=0x80000000; after the edge, status=1001.
REQ-029 SUB with S=1, op1=5, rm=5, imm=0, shift_operand=0 -> result 0; after the edge, status=0110. A following SBC with op1=5, rm=5 -> result 0 (C=1).
REQ-030 imm=1, shift_operand=0x4FF, MOV -> ALU_result=0xFF000000; then shift_operand=0x0C3, imm=0, rm=0x80000001 (ASR #1) -> 0xC0000000.
REQ-031 LDR with Mem_R_EN=1, EXE_CMD=0100, op1=0x100, shift_operand=0x004 -> ALU_result=0x104, store_data=rm, and status unchanged with S=0.
REQ-032 B=1, pc=0x20, signed_imm_24=0xFFFFFE -> branch_addr=0x18, branch_taken=1; with sel_src1=01 and fwd_mem=0x10, ADD with Val2=1 -> 0x11.
REQ-033 Set status=1111 via S=1, then assert rst between edges -> status=0000 immediately, with no further change until S=1.
